// File: rtl/phy_out_pkg.sv
// Shared types and defaults for the output PHY transmit path.
package phy_out_pkg;

    typedef enum logic [2:0] {
        RST,
        TRAIN,
        IDLE,
        SYNC,
        DATA,
        CHK,
        GAP
    } state_e;

    localparam logic [7:0] TRAIN_PATTERN_DEF = 8'hF0;
    localparam logic [7:0] IDLE_PATTERN_DEF  = 8'h00;
    localparam logic [7:0] SYNC_WORD_DEF     = 8'hBC;

    // Counter only ever reaches (limit - 1), so clog2 of the largest limit suffices.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/phy_out_tx_ctrl.sv
// Serializer transmit sequencer: reset hold, training burst, then SYNC/payload/gap frames.
// Define PHY_OUT_CHKSUM_EN to append an XOR checksum word after each frame's payload.
module phy_out_tx_ctrl
    import phy_out_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    RST_HOLD_CYCLES = 8,
    parameter int                    TRAIN_WORDS     = 32,
    parameter int                    GAP_WORDS       = 2,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN   = DATA_WIDTH'(TRAIN_PATTERN_DEF),
    parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN    = DATA_WIDTH'(IDLE_PATTERN_DEF),
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD       = DATA_WIDTH'(SYNC_WORD_DEF)
) (
    input  logic                  clk_div_in,
    input  logic                  reset,
    input  logic                  retrain,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_last,
    output logic                  tx_ready,
    output logic                  serdes_rst,
    output logic [DATA_WIDTH-1:0] data_to_phy,
    output logic                  link_up,
    output logic                  underrun
);

    localparam int CNT_W = cnt_width(RST_HOLD_CYCLES, TRAIN_WORDS, GAP_WORDS);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_WORDS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_WORDS - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  retrain_pend_q, retrain_pend_d;
    logic                  serdes_rst_q, serdes_rst_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  link_up_q, link_up_d;
    logic                  underrun_q, underrun_d;
    logic                  handshake;
`ifdef PHY_OUT_CHKSUM_EN
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
`endif

    assign tx_ready    = (state_q == DATA);
    assign handshake   = tx_valid && tx_ready;
    assign serdes_rst  = serdes_rst_q;
    assign data_to_phy = data_q;
    assign link_up     = link_up_q;
    assign underrun    = underrun_q;

    always_ff @(posedge clk_div_in) begin
        if (reset) begin
            state_q        <= RST;
            cnt_q          <= '0;
            retrain_pend_q <= 1'b0;
            serdes_rst_q   <= 1'b1;
            data_q         <= IDLE_PATTERN;
            link_up_q      <= 1'b0;
            underrun_q     <= 1'b0;
`ifdef PHY_OUT_CHKSUM_EN
            acc_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retrain_pend_q <= retrain_pend_d;
            serdes_rst_q   <= serdes_rst_d;
            data_q         <= data_d;
            link_up_q      <= link_up_d;
            underrun_q     <= underrun_d;
`ifdef PHY_OUT_CHKSUM_EN
            acc_q          <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RST:   if (!retrain && cnt_q == RST_LAST) state_d = TRAIN;
            TRAIN: begin
                if (retrain)                      state_d = RST;
                else if (cnt_q == TRAIN_LAST)     state_d = IDLE;
            end
            IDLE: begin
                if (retrain)                      state_d = RST;
                else if (tx_valid)                state_d = SYNC;
            end
            SYNC:  state_d = DATA;
`ifdef PHY_OUT_CHKSUM_EN
            DATA:  if (handshake && tx_last) state_d = CHK;
            CHK:   state_d = GAP;
`else
            DATA:  if (handshake && tx_last) state_d = GAP;
`endif
            // A waiting frame skips IDLE so back-to-back frames see exactly GAP_WORDS idles.
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    if (retrain_pend_q || retrain) state_d = RST;
                    else if (tx_valid)             state_d = SYNC;
                    else                           state_d = IDLE;
                end
            end
            default: state_d = RST;
        endcase

        if (state_d != state_q || (state_q == RST && retrain))
            cnt_d = '0;
        else if (state_q == RST || state_q == TRAIN || state_q == GAP)
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = '0;

        if (state_d == RST)
            retrain_pend_d = 1'b0;
        else if (retrain && (state_q == SYNC || state_q == DATA ||
                             state_q == CHK  || state_q == GAP))
            retrain_pend_d = 1'b1;
        else
            retrain_pend_d = retrain_pend_q;
    end

    always_comb begin
        serdes_rst_d = (state_q == RST);
        link_up_d    = (state_q == IDLE) || (state_q == SYNC) || (state_q == DATA) ||
                       (state_q == CHK)  || (state_q == GAP);
        underrun_d   = (state_q == DATA) && !tx_valid;
        data_d       = IDLE_PATTERN;
        unique case (state_q)
            TRAIN:   data_d = TRAIN_PATTERN;
            SYNC:    data_d = SYNC_WORD;
            DATA:    data_d = tx_valid ? tx_data : IDLE_PATTERN;
`ifdef PHY_OUT_CHKSUM_EN
            CHK:     data_d = acc_q;
`endif
            default: data_d = IDLE_PATTERN;
        endcase
`ifdef PHY_OUT_CHKSUM_EN
        if (state_q == SYNC)  acc_d = '0;
        else if (handshake)   acc_d = acc_q ^ tx_data;
        else                  acc_d = acc_q;
`endif
    end

endmodule

// File: tb/tb_phy_out_tx_ctrl.sv
// Self-checking bench for phy_out_tx_ctrl; expected word streams are built from frame descriptions.
// Honours PHY_OUT_CHKSUM_EN the same way as the design.
module tb_phy_out_tx_ctrl;

    localparam int HOLD = 8;
    localparam int TRN  = 32;
    localparam int GAPW = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       retrain = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       serdes_rst;
    logic [7:0] data_to_phy;
    logic       link_up;
    logic       underrun;

    int n_checks = 0;
    int n_fail   = 0;

    phy_out_tx_ctrl dut (
        .clk_div_in  (clk),
        .reset       (reset),
        .retrain     (retrain),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .serdes_rst  (serdes_rst),
        .data_to_phy (data_to_phy),
        .link_up     (link_up),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expect HOLD words with serdes_rst high, TRN training words, then the first idle with link up.
    task automatic train_seq(input string tag);
        int   n_rst = 0;
        int   n_trn = 0;
        int   guard = 0;
        logic bad_link = 1'b0;
        step();
        while (serdes_rst === 1'b1 && guard < 200) begin
            if (data_to_phy !== 8'h00 || link_up !== 1'b0) bad_link = 1'b1;
            n_rst++; guard++; step();
        end
        while (serdes_rst === 1'b0 && data_to_phy === 8'hF0 && guard < 200) begin
            if (link_up !== 1'b0) bad_link = 1'b1;
            n_trn++; guard++; step();
        end
        chk({tag, "_hold_cycles"}, n_rst, HOLD);
        chk({tag, "_train_words"}, n_trn, TRN);
        chk({tag, "_link_low_during_bringup"}, bad_link, 1'b0);
        chk({tag, "_first_idle_data"}, data_to_phy, 8'h00);
        chk({tag, "_first_idle_link_up"}, link_up, 1'b1);
        chk({tag, "_first_idle_serdes_rst"}, serdes_rst, 1'b0);
        $display("txn %s: hold=%0d train=%0d", tag, n_rst, n_trn);
    endtask

    // Sends one frame; stalls[i] idle cycles precede word i. In b2b mode the last gap
    // word is left to be observed as the first sample of the following frame.
    task automatic send_frame(input string tag, input logic [7:0] words[$], input int stalls[$],
                              input int retrain_idx, input bit b2b);
        logic [7:0] exp_d[$];
        bit         exp_u[$];
        logic [7:0] got_d[$];
        bit         got_u[$];
        logic       link_bad = 1'b0;
        logic [7:0] x = 8'h00;
        int         n = words.size();
        int         stall_total = 0;
        int         ready_cnt = 0;
        int         gap_n = b2b ? GAPW - 1 : GAPW;
        int         post;

        exp_d.push_back(8'hBC); exp_u.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < stalls[i]; s++) begin
                exp_d.push_back(8'h00); exp_u.push_back(1'b1);
            end
            stall_total += stalls[i];
            exp_d.push_back(words[i]); exp_u.push_back(1'b0);
            x ^= words[i];
        end
        post = gap_n;
`ifdef PHY_OUT_CHKSUM_EN
        exp_d.push_back(x); exp_u.push_back(1'b0);
        post++;
`endif
        for (int g = 0; g < gap_n; g++) begin
            exp_d.push_back(8'h00); exp_u.push_back(1'b0);
        end

        tx_valid = 1'b1; tx_data = words[0]; tx_last = (n == 1);
        step();
        chk({tag, "_pre_sync_idle"}, data_to_phy, 8'h00);
        step();
        got_d.push_back(data_to_phy); got_u.push_back(underrun);
        if (link_up !== 1'b1) link_bad = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int s = 0; s < stalls[i]; s++) begin
                tx_valid = 1'b0;
                if (tx_ready) ready_cnt++;
                step();
                got_d.push_back(data_to_phy); got_u.push_back(underrun);
                if (link_up !== 1'b1) link_bad = 1'b1;
            end
            tx_valid = 1'b1; tx_data = words[i]; tx_last = (i == n - 1);
            retrain = (i == retrain_idx);
            if (tx_ready) ready_cnt++;
            step();
            retrain = 1'b0;
            got_d.push_back(data_to_phy); got_u.push_back(underrun);
            if (link_up !== 1'b1) link_bad = 1'b1;
        end
        tx_valid = 1'b0; tx_last = 1'b0;
        for (int p = 0; p < post; p++) begin
            if (tx_ready) ready_cnt++;
            step();
            got_d.push_back(data_to_phy); got_u.push_back(underrun);
            if (link_up !== 1'b1) link_bad = 1'b1;
        end

        for (int i = 0; i < exp_d.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_underrun%0d", tag, i), got_u[i], exp_u[i]);
        end
        chk({tag, "_ready_cycles"}, ready_cnt, n + stall_total);
        chk({tag, "_link_up"}, link_bad, 1'b0);
        $display("txn %s: words=%0d stalls=%0d checksum=0x%02h ready=%0d", tag, n, stall_total, x, ready_cnt);
    endtask

    initial begin
        logic [7:0] q_w[$];
        int         q_s[$];
        int         len;
        bit         b2b;

        reset = 1'b1;
        repeat (3) step();
        chk("rst_serdes_rst", serdes_rst, 1'b1);
        chk("rst_data", data_to_phy, 8'h00);
        chk("rst_link_up", link_up, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        $display("txn reset: serdes_rst=%0b data=0x%02h", serdes_rst, data_to_phy);
        reset = 1'b0;
        train_seq("init");

        q_w = '{8'h11, 8'h22, 8'h33, 8'h44};
        q_s = '{0, 0, 0, 0};
        send_frame("frameA", q_w, q_s, -1, 1'b0);

        q_s = '{0, 0, 2, 0};
        send_frame("frameB_stall", q_w, q_s, -1, 1'b0);

        for (int f = 0; f < 5; f++) begin
            q_w = {};
            q_s = {};
            len = $urandom_range(6, 1);
            for (int i = 0; i < len; i++) begin
                q_w.push_back(8'($urandom_range(255, 0)));
                q_s.push_back($urandom_range(2, 0));
            end
            b2b = (f < 4) ? 1'($urandom_range(1, 0)) : 1'b0;
            send_frame($sformatf("rand%0d_b2b%0d", f, b2b), q_w, q_s, -1, b2b);
        end

        q_w = '{8'h11, 8'h22, 8'h33, 8'h44};
        q_s = '{0, 0, 0, 0};
        send_frame("frameC_retrain", q_w, q_s, 1, 1'b0);
        train_seq("after_frame_retrain");

        retrain = 1'b1;
        step();
        retrain = 1'b0;
        train_seq("idle_retrain");

        tx_valid = 1'b1; tx_data = 8'h5A; tx_last = 1'b0;
        step();
        step();
        chk("midframe_in_data", tx_ready, 1'b1);
        step();
        reset = 1'b1;
        step();
        tx_valid = 1'b0;
        chk("midreset_serdes_rst", serdes_rst, 1'b1);
        chk("midreset_data", data_to_phy, 8'h00);
        chk("midreset_tx_ready", tx_ready, 1'b0);
        chk("midreset_link_up", link_up, 1'b0);
        chk("midreset_underrun", underrun, 1'b0);
        $display("txn midframe_reset: serdes_rst=%0b data=0x%02h link_up=%0b", serdes_rst, data_to_phy, link_up);
        reset = 1'b0;
        train_seq("after_midreset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
